// File: rtl/display_pkg.sv
// Shared constants and types for the HH.MM.SS seven-segment scan driver.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package display_pkg;

   localparam int DIGIT_COUNT = 8;

   typedef logic [3:0] digit_code_t;

   localparam digit_code_t CODE_BLANK = 4'd10;
   localparam digit_code_t CODE_DASH  = 4'd11;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Entry n is the pattern for decimal digit n (index 0 is the rightmost element).
   localparam logic [9:0][6:0] SEG_DIGITS = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef struct packed {
      logic [4:0] hour;
      logic [5:0] minute;
      logic [5:0] second;
      logic [2:0] mask;
   } snapshot_t;

   // Splits a field into {tens, ones} codes, or two dashes when out of range.
   function automatic logic [7:0] to_digits(input logic [5:0] v, input logic [5:0] max_v);
      digit_code_t tens;
      digit_code_t ones;
      if (v > max_v) begin
         return {CODE_DASH, CODE_DASH};
      end
      tens = 4'(v / 6'd10);
      ones = 4'(v % 6'd10);
      return {tens, ones};
   endfunction

endpackage

// File: rtl/hms_display_driver_seg7_decoder.sv
// Combinational digit-code to active-low seven-segment decoder.
// Codes 0..9 are decimal digits, CODE_DASH lights g only, anything else is blank.
module seg7_decoder
   import display_pkg::*;
(
   input  digit_code_t code,
   output logic [6:0]  seg
);

   // NOTE: every path assigns seg, so no latch can be inferred.
   always_comb begin
      if (code <= 4'd9) begin
         seg = SEG_DIGITS[code];
      end else if (code == CODE_DASH) begin
         seg = SEG_DASH;
      end else begin
         seg = SEG_BLANK;
      end
   end

endmodule

// File: rtl/hms_display_driver.sv
// Eight-digit multiplexed seven-segment driver showing HH.MM.SS on digits 5..0,
// with per-field blinking and a once-per-frame snapshot of the time inputs.
module hms_display_driver
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = 100_000,
   parameter int BLINK_TICKS = 500
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic [4:0] hour_in,
   input  logic [5:0] min_in,
   input  logic [5:0] sec_in,
   input  logic [2:0] blink_mask,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   logic [CW-1:0] cnt;
   logic [2:0]    digit;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
   snapshot_t     snap;

   logic          tick;
   logic          frame_end;
   logic          blink_wrap;
   logic [2:0]    digit_next;
   logic          phase_next;
   snapshot_t     snap_next;
   logic [2:0]    field_blank;
   logic [7:0]    hour_d;
   logic [7:0]    min_d;
   logic [7:0]    sec_d;
   digit_code_t   code;
   logic [6:0]    dec_seg;

   assign tick       = (cnt == CW'(REFRESH_DIV - 1));
   assign frame_end  = tick && (digit == 3'(DIGIT_COUNT - 1));
   assign blink_wrap = tick && (blink_cnt == BW'(BLINK_TICKS - 1));
   assign digit_next = digit + 3'd1;
   assign phase_next = blink_phase ^ blink_wrap;

   // Decode from the values that will be in force after this edge, so the digit
   // presented at a frame-end edge already belongs to the newly captured frame.
   always_comb begin
      snap_next   = frame_end ? {hour_in, min_in, sec_in, blink_mask} : snap;
      field_blank = phase_next ? snap_next.mask : 3'b000;
      hour_d      = to_digits({1'b0, snap_next.hour}, 6'd23);
      min_d       = to_digits(snap_next.minute, 6'd59);
      sec_d       = to_digits(snap_next.second, 6'd59);
      code        = CODE_BLANK;
      case (digit_next)
         3'd5:    code = field_blank[2] ? CODE_BLANK : hour_d[7:4];
         3'd4:    code = field_blank[2] ? CODE_BLANK : hour_d[3:0];
         3'd3:    code = field_blank[1] ? CODE_BLANK : min_d[7:4];
         3'd2:    code = field_blank[1] ? CODE_BLANK : min_d[3:0];
         3'd1:    code = field_blank[0] ? CODE_BLANK : sec_d[7:4];
         3'd0:    code = field_blank[0] ? CODE_BLANK : sec_d[3:0];
         default: code = CODE_BLANK;
      endcase
   end

   seg7_decoder u_dec (
      .code (code),
      .seg  (dec_seg)
   );

   // NOTE: state registers use non-blocking assignments so every update in this
   // block sees the pre-edge values, regardless of statement order.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         cnt         <= '0;
         digit       <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         snap        <= '0;
         an          <= 8'hFF;
         seg         <= SEG_BLANK;
         dp          <= 1'b1;
      end else begin
         cnt <= tick ? '0 : cnt + CW'(1);
         if (tick) begin
            digit       <= digit_next;
            blink_cnt   <= blink_wrap ? '0 : blink_cnt + BW'(1);
            blink_phase <= phase_next;
            snap        <= snap_next;
            an          <= ~(8'b1 << digit_next);
            seg         <= dec_seg;
            dp          <= !((digit_next == 3'd4) || (digit_next == 3'd2));
         end
      end
   end

endmodule

// File: tb/tb_hms_display_driver.sv
// Scoreboard bench for hms_display_driver: stimulus queues the hand-derived
// expected display for every tick, a negedge monitor compares on each output change.
module tb_hms_display_driver;

   localparam int REFRESH_DIV = 4;
   localparam int BLINK_TICKS = 2;

   logic       clk_100MHz = 1'b0;
   logic       reset;
   logic [4:0] hour_in;
   logic [5:0] min_in;
   logic [5:0] sec_in;
   logic [2:0] blink_mask;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;

   always #5 clk_100MHz = ~clk_100MHz;

   hms_display_driver #(
      .REFRESH_DIV (REFRESH_DIV),
      .BLINK_TICKS (BLINK_TICKS)
   ) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .hour_in    (hour_in),
      .min_in     (min_in),
      .sec_in     (sec_in),
      .blink_mask (blink_mask),
      .an         (an),
      .seg        (seg),
      .dp         (dp)
   );

   typedef logic [15:0] obs_t;  // {an, seg, dp}

   obs_t       exp_q[$];
   int         vectors     = 0;
   int         miscompares = 0;

   int         k;            // ticks since the last reset release
   int         cur[6];       // digit codes on positions 0..5 for the running frame
   int         pend[6];      // hand-computed codes for the inputs currently applied
   logic [2:0] cur_mask;
   logic [2:0] pend_mask;

   function automatic logic [6:0] seg_of(input int code);
      case (code)
         0:       return 7'h40;
         1:       return 7'h79;
         2:       return 7'h24;
         3:       return 7'h30;
         4:       return 7'h19;
         5:       return 7'h12;
         6:       return 7'h02;
         7:       return 7'h78;
         8:       return 7'h00;
         9:       return 7'h10;
         11:      return 7'h3F;
         default: return 7'h7F;
      endcase
   endfunction

   // Monitor: every change of {an,seg,dp} is one presented vector.
   initial begin
      obs_t prev;
      obs_t now;
      obs_t want;
      prev = 'x;
      forever begin
         @(negedge clk_100MHz);
         now = {an, seg, dp};
         if (now !== prev) begin
            prev = now;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_output at %0t: got an=%h seg=%h dp=%b, nothing expected",
                        $time, now[15:8], now[7:1], now[0]);
            end else begin
               want = exp_q.pop_front();
               if (now !== want) begin
                  miscompares++;
                  $display("FAIL display at %0t: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                           $time, now[15:8], now[7:1], now[0], want[15:8], want[7:1], want[0]);
               end
            end
         end
      end
   end

   task automatic clear_frame();
      k = 0;
      for (int i = 0; i < 6; i++) cur[i] = 0;
      cur_mask = 3'b000;
   endtask

   // Hold reset for n edges; the display must go blank with all anodes off.
   task automatic apply_reset(input int n);
      reset = 1'b1;
      exp_q.push_back({8'hFF, 7'h7F, 1'b1});
      repeat (n) @(posedge clk_100MHz);
      #1;
      reset = 1'b0;
      clear_frame();
   endtask

   // Queue the expected view for the next digit tick, then let it happen.
   task automatic tick();
      int         d;
      int         code;
      logic       phase;
      logic [7:0] an_e;
      logic       dp_e;
      k++;
      d = k % 8;
      if (d == 0) begin
         cur      = pend;
         cur_mask = pend_mask;
      end
      phase = ((k / BLINK_TICKS) % 2) == 1;
      if (d >= 6) code = 10;
      else if (phase && cur_mask[d / 2]) code = 10;
      else code = cur[d];
      an_e = ~(8'b1 << d);
      dp_e = !((d == 4) || (d == 2));
      exp_q.push_back({an_e, seg_of(code), dp_e});
      repeat (REFRESH_DIV) @(posedge clk_100MHz);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      hour_in    = '0;
      min_in     = '0;
      sec_in     = '0;
      blink_mask = '0;
      pend       = '{0, 0, 0, 0, 0, 0};
      pend_mask  = 3'b000;
      apply_reset(3);

      // 13:05:59 — zeros until the first frame end, then two full frames.
      hour_in = 5'd13; min_in = 6'd5; sec_in = 6'd59;
      pend = '{9, 5, 5, 0, 3, 1};
      repeat (23) tick();

      // sec 58 captured at frame end, then changed to 59 mid-frame on digit 3.
      sec_in = 6'd58; pend[0] = 8;
      repeat (4) tick();
      sec_in = 6'd59; pend[0] = 9;
      repeat (13) tick();

      // Out-of-range hour and minute show dashes; seconds stay normal.
      hour_in = 5'd24; min_in = 6'd60; sec_in = 6'd7;
      pend = '{7, 0, 11, 11, 11, 11};
      repeat (16) tick();

      // Minute field blinks every two ticks.
      hour_in = 5'd13; min_in = 6'd42; sec_in = 6'd59; blink_mask = 3'b010;
      pend = '{9, 5, 2, 4, 3, 1}; pend_mask = 3'b010;
      repeat (21) tick();   // ends showing digit 5

      // Reset in the middle of digit 5, then restart from digit 0.
      @(negedge clk_100MHz);
      reset = 1'b1;
      exp_q.push_back({8'hFF, 7'h7F, 1'b1});
      @(posedge clk_100MHz);
      #1;
      reset = 1'b0;
      clear_frame();
      repeat (12) tick();

      repeat (2) @(negedge clk_100MHz);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected vectors never presented, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hms_display_driver.md
# hms_display_driver

Time-multiplexed 8-digit seven-segment driver that sits directly downstream of the 24-hour clock. It consumes the binary hour/minute/second values, converts each to two decimal digits, and scans them onto the board display as HH.MM.SS on digits 5..0, with digits 7..6 blank. It also provides per-field blinking so a field being set can flash. Inputs are snapshotted once per scan frame, so a frame never mixes old and new time.

## Interface
- REFRESH_DIV, 100_000: clk_100MHz cycles per digit tick. Must be ≥2. The default gives a 1 kHz digit rate.
- BLINK_TICKS, 500: digit ticks per blink half-period. Must be ≥1.
- clk_100MHz  in  1  sole clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- hour_in  in  5  binary hour; valid 0..23.
- min_in  in  6  binary minute; valid 0..59.
- sec_in  in  6  binary second; valid 0..59.
- blink_mask  in  3  bit2 = hour, bit1 = min, bit0 = sec. A 1 blinks that field.
- an  out  8  digit anodes, active-low, one-hot-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- Prescaler
  - cnt counts 0..REFRESH_DIV-1 and wraps.
  - tick is high for one cycle when cnt == REFRESH_DIV-1.
- Digit index
  - digit (3 bits) increments on each tick, wrapping 7→0.
- Snapshot
  - On a tick where digit == 7 (frame end), the snapshot registers capture hour_in, min_in, sec_in and blink_mask.
  - All display decoding uses only the snapshot.
- Conversion
  - Each 6-bit field becomes tens = v/10 and ones = v%10, using constant-divide logic.
  - hour > 23, min > 59 or sec > 59: both digits of that field show dash (segment g only).
- Digit map
  - 7, 6: blank.
  - 5: hour tens. 4: hour ones.
  - 3: min tens. 2: min ones.
  - 1: sec tens. 0: sec ones.
  - Leading zeros are shown (e.g. 07).
- dp is lit (0) on digits 4 and 2 only.
- Blink
  - blink_cnt counts ticks from 0 to BLINK_TICKS-1. On wrap it toggles blink_phase.
  - While blink_phase = 1, fields whose snapshot mask bit is set show blank. dp stays as normal.
- Blank means seg = 7'h7F; the anode is still driven.
- Outputs an, seg and dp are registered.

## Timing
- Reset, synchronous and taking priority over everything:
  - cnt = 0, digit = 0, blink_cnt = 0, blink_phase = 0.
  - Snapshot registers = 0.
  - an = 8'hFF, seg = 7'h7F, dp = 1.
- Output registers update on each tick-cycle edge, presenting the new digit:
  - an = ~(1 << next digit).
  - seg and dp correspond to that digit.
- First tick after reset shows digit 1 driven from the zeroed snapshot. Display reads 00.00.00 until the first frame-end capture.
- Input-to-display latency: an input change is visible no later than 8 ticks plus 1 cycle after it is stable at frame end.
- Inputs are sampled only on frame-end ticks; changes between those ticks are ignored.
- Frame-end tick coinciding with blink wrap: both updates happen on the same edge, and the new mask and new phase apply from the next digit.
- Reset asserted mid-frame: all state returns to reset values on the next edge. No partial output persists.

## Structure
- Package display_pkg holds:
  - Segment constants SEG_BLANK = 7'h7F and SEG_DASH = 7'h3F, plus the 0–9 segment table.
  - Digit code type: 4 bits, where 10 = blank and 11 = dash.
  - DIGIT_COUNT = 8.
- Sub-module seg7_decoder: purely combinational, mapping a 4-bit digit code to 7 active-low segments. Instantiated once, driven by a digit-indexed code mux.
- The top holds the prescaler, digit counter, snapshot, blink logic and output registers.

## Test plan
All scenarios use REFRESH_DIV = 4 and BLINK_TICKS = 2.
- Reset held for 3 cycles, then released → an = FF, seg = 7F, dp = 1 until the first tick. Then an = FD, seg = 40 ("0").
- Inputs hour = 13, min = 5, sec = 59, held for 2 frames → in the second frame:
  - digits 5..0 show 1, 3, 0, 5, 5, 9.
  - dp = 0 only while an = EF and while an = FB.
  - an = 7F and BF show seg = 7F.
- Input change mid-frame (sec 58→59 while digit = 3) → current frame still shows 58 on digits 1/0. The next frame shows 59.
- hour = 24, min = 60 → digits 5, 4, 3, 2 show seg = 3F. Seconds display normally.
- blink_mask = 3'b010 with min = 42 → digits 3/2 alternate between "4","2" and 7F every 2 ticks. Hour and seconds stay steady.
- Reset asserted while digit = 5 → outputs return to the reset values on the next edge. Counting restarts from digit 0.
